// File: rtl/bus_pkg.sv
// Shared definitions for the serial burst bus: FSM state encoding and
// counter-width helpers used by both the slave and master ports.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_WDATA   = 3'd3,
    ST_WCOMMIT = 3'd4,
    ST_RREQ    = 3'd5,
    ST_RWAIT   = 3'd6,
    ST_RDATA   = 3'd7
  } state_e;

  // Bits needed for a counter that runs 0 .. n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Generic shift register: parallel load, LSB-first serial out, serial in at MSB.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] data_q, data_d;

  // Load has priority over shift; shifting moves toward bit 0.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d            = data_q >> 1;
      data_d[WIDTH-1]   = ser_i;
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data_q <= '0;
    else       data_q <= data_d;
  end

  assign ser_o = data_q[0];
  assign par_o = data_q;

endmodule

// File: rtl/burst_slave_port.sv
// Serial burst slave: receives address/length/write data bit-serially from a
// master and performs burst reads/writes on a parallel memory interface.
//
// Handshake: the master may present a new transaction bit only while sready=1
// (IDLE); after that, each cycle with mvalid=1 delivers exactly one swdata bit
// in ADDR/LEN/WDATA, and mvalid is ignored in WCOMMIT/RREQ/RWAIT/RDATA. Read
// data is returned on srdata, one bit per cycle, qualified by svalid.
module burst_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready
);

  localparam int RX_W  = max3(ADDR_WIDTH, LEN_WIDTH, DATA_WIDTH);
  localparam int CNT_W = cnt_w(RX_W);
  localparam int LAT_W = cnt_w(MEM_LATENCY);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] memaddr_q, memaddr_d;
  logic [DATA_WIDTH-1:0] memwdata_q, memwdata_d;

  logic                  rx_shift, tx_load, tx_shift;
  logic [RX_W-2:0]       rx_par;
  logic [RX_W-1:0]       rx_next;
  logic                  rx_ser_unused;
  logic                  tx_ser;
  logic [DATA_WIDTH-1:0] tx_word_unused;

  // The rx register holds all but the newest bit; the field value is read
  // from rx_next in the cycle its final bit arrives on swdata, taking the
  // top n bits, so one register serves address, length and data fields.
  assign rx_next = {swdata, rx_par};

  serial_shift_reg #(.WIDTH(RX_W - 1)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (rx_shift),
    .ser_i       (swdata),
    .ser_o       (rx_ser_unused),
    .par_o       (rx_par)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (tx_load),
    .load_data_i (smemrdata),
    .shift_i     (tx_shift),
    .ser_i       (1'b0),
    .ser_o       (tx_ser),
    .par_o       (tx_word_unused)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    bit_cnt_d  = bit_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mvalid) begin
          rx_shift  = 1'b1;
          mode_d    = smode;
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mvalid) begin
          rx_shift = 1'b1;
          if (bit_cnt_q == ADDR_LAST) begin
            addr_d    = rx_next[RX_W-1 -: ADDR_WIDTH];
            bit_cnt_d = '0;
            state_d   = ST_LEN;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LEN: begin
        if (mvalid) begin
          rx_shift = 1'b1;
          if (bit_cnt_q == LEN_LAST) begin
            beats_d   = rx_next[RX_W-1 -: LEN_WIDTH];
            bit_cnt_d = '0;
            if (mode_q) begin
              state_d = ST_WDATA;
            end else begin
              memaddr_d = addr_q;
              state_d   = ST_RREQ;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (mvalid) begin
          rx_shift = 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            memwdata_d = rx_next[RX_W-1 -: DATA_WIDTH];
            memaddr_d  = addr_q;
            bit_cnt_d  = '0;
            state_d    = ST_WCOMMIT;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WCOMMIT: begin
        if (beats_q != '0) begin
          beats_d = beats_q - LEN_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = ST_WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RREQ: begin
        lat_cnt_d = '0;
        state_d   = ST_RWAIT;
      end
      ST_RWAIT: begin
        // Last wait cycle is T+MEM_LATENCY: memory data is valid now.
        if (lat_cnt_q == LAT_LAST) begin
          tx_load   = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_RDATA;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_RDATA: begin
        tx_shift = 1'b1;
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
          if (beats_q != '0) begin
            beats_d   = beats_q - LEN_WIDTH'(1);
            addr_d    = addr_q + ADDR_WIDTH'(1);
            memaddr_d = addr_q + ADDR_WIDTH'(1);
            state_d   = ST_RREQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      addr_q     <= '0;
      beats_q    <= '0;
      bit_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      bit_cnt_q  <= bit_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
    end
  end

  assign smemwen   = (state_q == ST_WCOMMIT);
  assign smemren   = (state_q == ST_RREQ);
  assign svalid    = (state_q == ST_RDATA);
  assign srdata    = svalid & tx_ser;
  assign sready    = (state_q == ST_IDLE);
  assign smemaddr  = memaddr_q;
  assign smemwdata = memwdata_q;

endmodule

// File: tb/tb_burst_slave_port.sv
// Bench for burst_slave_port: table of bursts plus hand-written corner cases,
// with a memory model and write/read scoreboards.
module tb_burst_slave_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LW  = 4;
  localparam int LAT = 2;

  logic          clk, rstn;
  logic [DW-1:0] smemrdata;
  logic          smemwen, smemren;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata;
  logic          swdata, smode, mvalid;
  logic          srdata, svalid, sready;

  burst_slave_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .smemrdata(smemrdata), .smemwen(smemwen),
    .smemren(smemren), .smemaddr(smemaddr), .smemwdata(smemwdata),
    .swdata(swdata), .smode(smode), .mvalid(mvalid), .srdata(srdata),
    .svalid(svalid), .sready(sready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (2-cycle read latency) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe0, rd_pipe1;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (smemwen) mem[smemaddr] <= smemwdata;
    rd_pipe0 <= smemren ? mem[smemaddr] : 8'($urandom);
    rd_pipe1 <= rd_pipe0;
  end
  assign smemrdata = rd_pipe1;

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0]    rd_word;
  int               rd_bits = 0;
  int               ren_cyc = 0;
  logic [AW+DW-1:0] exp_w;
  logic [DW-1:0]    exp_r;

  always @(negedge clk) begin
    if (!rstn) begin
      rd_bits = 0;
    end else begin
      if (smemwen) begin
        check("sready_busy", {31'd0, sready}, 32'd0);
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", smemaddr, smemwdata);
        end else begin
          exp_w = exp_wr_q.pop_front();
          check("write", {12'd0, smemaddr, smemwdata}, {12'd0, exp_w});
        end
      end
      if (smemren) ren_cyc = cyc;
      if (svalid) begin
        if (rd_bits == 0) check("ren_to_rdata", cyc - ren_cyc, 32'd3);
        rd_word = {srdata, rd_word[DW-1:1]};
        rd_bits++;
        if (rd_bits == DW) begin
          rd_bits = 0;
          if (exp_rd_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_read: word 0x%0h, none expected", rd_word);
          end else begin
            exp_r = exp_rd_q.pop_front();
            check("read", {24'd0, rd_word}, {24'd0, exp_r});
          end
        end
      end else if (rd_bits != 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL read_window_gap: got %0d bits, expected %0d", rd_bits, DW);
        rd_bits = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] dbuf [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400; i++) begin
      if (sready) break;
      tick();
    end
    check("wait_ready", {31'd0, sready}, 32'd1);
  endtask

  task automatic send_bit(input logic b, input int stall_pct);
    if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
      mvalid = 1'b0;
      swdata = ~b;
      repeat ($urandom_range(1, 3)) tick();
    end
    mvalid = 1'b1;
    swdata = b;
    tick();
  endtask

  task automatic send_field(input logic [31:0] v, input int n, input int stall_pct, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        mvalid = 1'b0;
        swdata = ~v[i];
        repeat (5) tick();
      end
      send_bit(v[i], stall_pct);
    end
  endtask

  task automatic preload_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  // Runs one transaction with data in dbuf; noise drives mvalid=1 with random
  // swdata for every busy cycle after the header of a read.
  task automatic run_txn(input logic mode, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int stall_pct, input int stall_at, input bit noise);
    logic [AW-1:0] a;
    wait_ready();
    smode = mode;
    send_bit(addr[0], 0);
    check("sready_after_accept", {31'd0, sready}, 32'd0);
    send_field({20'd0, addr} >> 1, AW - 1, stall_pct, stall_at - 1);
    if (mode) begin
      send_field({28'd0, len}, LW, stall_pct, -1);
      for (int b = 0; b <= int'(len); b++) begin
        a = addr + AW'(b);
        exp_wr_q.push_back({a, dbuf[b]});
        send_field({24'd0, dbuf[b]}, DW, stall_pct, -1);
        mvalid = 1'b0;
        tick();
      end
    end else begin
      for (int b = 0; b <= int'(len); b++) exp_rd_q.push_back(dbuf[b]);
      send_field({28'd0, len}, LW, stall_pct, -1);
      mvalid = 1'b0;
      if (noise) begin
        for (int i = 0; i < 400 && !sready; i++) begin
          mvalid = 1'b1;
          swdata = 1'($urandom);
          tick();
        end
        mvalid = 1'b0;
      end
    end
    mvalid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          mode;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [3:0][DW-1:0] data;
    int            stall;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs [6];
  vec_t v;
  logic [AW-1:0] ra;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mode:1'b1, addr:12'h0A5, len:4'd0, data:32'h0000003C, stall:0,  exp_last:12'h0A5};
    vecs[1] = '{mode:1'b0, addr:12'h100, len:4'd2, data:32'h00332211, stall:0,  exp_last:12'h102};
    vecs[2] = '{mode:1'b1, addr:12'hFFF, len:4'd1, data:32'h00005EA1, stall:0,  exp_last:12'h000};
    vecs[3] = '{mode:1'b1, addr:12'h3F0, len:4'd3, data:32'h7EFF8001, stall:25, exp_last:12'h3F3};
    vecs[4] = '{mode:1'b0, addr:12'hFFE, len:4'd3, data:32'h69963CC3, stall:25, exp_last:12'h001};
    vecs[5] = '{mode:1'b0, addr:12'h5A5, len:4'd0, data:32'h000000F0, stall:0,  exp_last:12'h5A5};

    // ---- reset ----
    rstn = 1'b0; mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #1;
    check("rst_sready", {31'd0, sready}, 32'd1);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("rst_smemwen", {31'd0, smemwen}, 32'd0);
    check("rst_smemren", {31'd0, smemren}, 32'd0);
    check("rst_svalid",  {31'd0, svalid},  32'd0);
    check("rst_smemaddr", {20'd0, smemaddr}, 32'd0);

    // ---- table ----
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      for (int b = 0; b < 4; b++) dbuf[b] = v.data[b];
      if (!v.mode) begin
        for (int b = 0; b <= int'(v.len); b++) begin
          ra = v.addr + AW'(b);
          preload_word(ra, dbuf[b]);
        end
      end
      run_txn(v.mode, v.addr, v.len, v.stall, -1, 1'b0);
      wait_ready();
      check("last_addr", {20'd0, smemaddr}, {20'd0, v.exp_last});
    end

    // ---- stall mid-address ----
    dbuf[0] = 8'h96;
    run_txn(1'b1, 12'h7FF, 4'd0, 0, 6, 1'b0);
    wait_ready();
    check("stall_addr", {20'd0, smemaddr}, 32'h7FF);

    // ---- reset in the middle of beat 2 of a write ----
    preload_word(12'h234, 8'h00);
    preload_word(12'h235, 8'h77);
    wait_ready();
    smode = 1'b1;
    send_field(32'h234, AW, 0, -1);
    send_field(32'h1, LW, 0, -1);
    exp_wr_q.push_back({12'h234, 8'h5A});
    send_field(32'h5A, DW, 0, -1);
    mvalid = 1'b0;
    tick();
    send_field(32'hC3, 4, 0, -1);
    rstn = 1'b0;
    mvalid = 1'b0;
    #1;
    check("rst_mid_sready",    {31'd0, sready},    32'd1);
    check("rst_mid_smemwen",   {31'd0, smemwen},   32'd0);
    check("rst_mid_smemren",   {31'd0, smemren},   32'd0);
    check("rst_mid_svalid",    {31'd0, svalid},    32'd0);
    check("rst_mid_srdata",    {31'd0, srdata},    32'd0);
    check("rst_mid_smemaddr",  {20'd0, smemaddr},  32'd0);
    check("rst_mid_smemwdata", {24'd0, smemwdata}, 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    check("rst_beat1_done", exp_wr_q.size(), 32'd0);
    dbuf[0] = 8'h5A;
    dbuf[1] = 8'h77;
    run_txn(1'b0, 12'h234, 4'd1, 0, -1, 1'b0);
    wait_ready();
    check("rst_readback_addr", {20'd0, smemaddr}, 32'h235);

    // ---- mvalid held high during read busy phases ----
    dbuf[0] = 8'hA5;
    dbuf[1] = 8'h3C;
    preload_word(12'h055, 8'hA5);
    preload_word(12'h056, 8'h3C);
    run_txn(1'b0, 12'h055, 4'd1, 0, -1, 1'b1);
    wait_ready();
    check("noise_last_addr", {20'd0, smemaddr}, 32'h056);
    dbuf[0] = 8'h81;
    run_txn(1'b1, 12'h600, 4'd0, 0, -1, 1'b0);
    wait_ready();
    check("after_noise_write", {20'd0, smemaddr}, 32'h600);

    // ---- full-length random burst: write then read back ----
    ra = AW'($urandom);
    for (int b = 0; b < 16; b++) dbuf[b] = DW'($urandom);
    run_txn(1'b1, ra, 4'hF, 10, -1, 1'b0);
    wait_ready();
    check("long_wr_last", {20'd0, smemaddr}, {20'd0, ra + 12'd15});
    run_txn(1'b0, ra, 4'hF, 10, -1, 1'b0);
    wait_ready();
    check("long_rd_last", {20'd0, smemaddr}, {20'd0, ra + 12'd15});

    // ---- drain ----
    for (int i = 0; i < 100 && (exp_wr_q.size() != 0 || exp_rd_q.size() != 0); i++) tick();
    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
